// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and helpers for the piso serializer
package piso_pkg;

    // Serializer control states: waiting for a word, emitting bits, holding the idle gap.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Bit-counter width for a given word width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - load/shift datapath with selectable output tap
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   load        : capture data_in (its first bit leaves directly via first_bit)
//   shift       : advance the register one position toward the output end
//   data_in     : parallel word
//   first_bit   : bit of data_in that is sent first
//   next_bit    : bit that goes out on the next shift
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             first_bit,
    output logic             next_bit
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // The first bit is registered into d_out on the load edge, so the register
    // holds the word already advanced by one position.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = (MSB_FIRST != 0) ? (data_in << 1) : (data_in >> 1);
        end else if (shift) begin
            shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign first_bit = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
    assign next_bit  = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with frame strobes
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   data_in      : word to send, sampled on load_valid && load_ready
//   load_valid   : producer has a word
//   load_ready   : block accepts a word this cycle
//   d_out        : serial data, 0 when idle
//   d_valid      : d_out carries a frame bit
//   frame_start  : first bit of a frame is on d_out
//   frame_end    : last bit of a frame is on d_out
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             d_out,
    output logic             d_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  PEN_CNT  = CW'(WIDTH - 2);
    localparam logic [3:0]     GAP_LAST = 4'(GAP - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    gap_q, gap_d;
    logic          d_out_q, d_out_d;
    logic          d_valid_q, d_valid_d;
    logic          frame_start_q, frame_start_d;
    logic          frame_end_q, frame_end_d;

    logic last_bit;
    logic gap_last;
    logic load;
    logic shift;
    logic first_bit;
    logic next_bit;

    assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);
    assign gap_last = (state_q == S_GAP) && (gap_q == GAP_LAST);

    // Ready in the final cycle of a frame (no gap) or of the gap lets the next
    // word's first bit follow the previous line activity without a bubble.
    assign load_ready = (state_q == S_IDLE) || (last_bit && (GAP == 0)) || gap_last;
    assign load       = load_valid && load_ready;
    assign shift      = (state_q == S_SHIFT) && !last_bit;

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .data_in   (data_in),
        .first_bit (first_bit),
        .next_bit  (next_bit)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gap_d         = gap_q;
        d_out_d       = 1'b0;
        d_valid_d     = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        if (load) begin
            state_d       = S_SHIFT;
            cnt_d         = '0;
            d_out_d       = first_bit;
            d_valid_d     = 1'b1;
            frame_start_d = 1'b1;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    if (last_bit) begin
                        state_d = (GAP > 0) ? S_GAP : S_IDLE;
                        gap_d   = '0;
                    end else begin
                        cnt_d       = cnt_q + 1'b1;
                        d_out_d     = next_bit;
                        d_valid_d   = 1'b1;
                        frame_end_d = (cnt_q == PEN_CNT);
                    end
                end
                S_GAP: begin
                    if (gap_last) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            gap_q         <= '0;
            d_out_q       <= 1'b0;
            d_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gap_q         <= gap_d;
            d_out_q       <= d_out_d;
            d_valid_q     <= d_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign d_out       = d_out_q;
    assign d_valid     = d_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;

endmodule
